// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, FSM state encoding and baud divisor helper.
package uart_pkg;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_ODD  = 1;
  localparam int unsigned PARITY_EVEN = 2;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  function automatic int unsigned baud_num(input int unsigned clk_freq,
                                           input int unsigned baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with occupancy count; read data is the head word (fall-through).
module uart_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      level_q;
  logic             push_ok, pop_ok;

  assign full_o  = (level_q == LVL_FULL);
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_ok && !pop_ok)      level_q <= level_q + 1'b1;
      else if (pop_ok && !push_ok) level_q <= level_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/uart_tx_fifo_param.sv
// Parametrised UART transmitter fed by a small input FIFO; back-to-back frames with no gap.
module uart_tx_fifo_param
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 1,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          tx_data_valid,
  input  logic [DATA_BITS-1:0]          tx_data,
  output logic                          tx_data_ready,
  output logic                          tx,
  output logic                          tx_busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned BAUD_NUM = baud_num(CLK_FREQ, BAUD_RATE);
  localparam int unsigned BW       = $clog2(BAUD_NUM);
  localparam int unsigned BITW     = $clog2(DATA_BITS);
  localparam logic [BW-1:0]   BAUD_LAST = BW'(BAUD_NUM - 1);
  localparam logic [BITW-1:0] BIT_LAST  = BITW'(DATA_BITS - 1);
  localparam logic            STOP_LAST = 1'(STOP_BITS - 1);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("DATA_BITS must be in 5..9");
  end
  if (PARITY > 2) begin : g_bad_parity
    $error("PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("STOP_BITS must be 1 or 2");
  end
  if (BAUD_NUM < 2) begin : g_bad_baud
    $error("CLK_FREQ/BAUD_RATE must be at least 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two, at least 2");
  end

  logic [2:0]           state_q, state_d;
  logic [BW-1:0]        baud_cnt_q, baud_cnt_d;
  logic [BITW-1:0]      bit_cnt_q, bit_cnt_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;

  logic                 fifo_full, fifo_empty, fifo_pop;
  logic [DATA_BITS-1:0] fifo_rdata;
  logic                 baud_end, frame_end;

  uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push_i  (tx_data_valid && tx_data_ready),
    .wdata_i (tx_data),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  assign baud_end  = (baud_cnt_q == BAUD_LAST);
  assign frame_end = (state_q == ST_STOP) && baud_end && (stop_cnt_q == STOP_LAST);
  assign fifo_pop  = !fifo_empty && ((state_q == ST_IDLE) || frame_end);

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    shift_d    = shift_q;
    par_d      = par_q;
    tx_d       = tx_q;
    baud_cnt_d = (state_q == ST_IDLE || baud_end) ? '0 : baud_cnt_q + 1'b1;
    case (state_q)
      ST_START: if (baud_end) begin
        tx_d    = shift_q[0];
        shift_d = shift_q >> 1;
        state_d = ST_DATA;
      end
      ST_DATA: if (baud_end) begin
        if (bit_cnt_q == BIT_LAST) begin
          bit_cnt_d = '0;
          if (PARITY != PARITY_NONE) begin
            tx_d    = par_q;
            state_d = ST_PARITY;
          end else begin
            tx_d    = 1'b1;
            state_d = ST_STOP;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
          tx_d      = shift_q[0];
          shift_d   = shift_q >> 1;
        end
      end
      ST_PARITY: if (baud_end) begin
        tx_d    = 1'b1;
        state_d = ST_STOP;
      end
      ST_STOP: if (baud_end) begin
        if (stop_cnt_q == STOP_LAST) begin
          stop_cnt_d = 1'b0;
          tx_d       = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          stop_cnt_d = 1'b1;
        end
      end
      default: ;
    endcase
    // A pop (from IDLE or at the last stop-bit edge) overrides the case above and starts a new frame.
    if (fifo_pop) begin
      state_d = ST_START;
      tx_d    = 1'b0;
      shift_d = fifo_rdata;
      par_d   = (^fifo_rdata) ^ (PARITY == PARITY_ODD);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      tx_q       <= tx_d;
    end
  end

  assign tx            = tx_q;
  assign tx_done       = frame_end;
  assign tx_busy       = (state_q != ST_IDLE) || (fifo_level != '0);
  assign tx_data_ready = !fifo_full;

endmodule

// File: tb/tb_uart_tx_fifo_param.sv
// Directed bench for uart_tx_fifo_param across four parameter sets sharing clock and reset.
module tb_uart_tx_fifo_param;

  logic       clk = 1'b0;
  logic       rstn;
  logic       tb_valid;
  logic [8:0] tb_data;
  logic [1:0] sel;

  logic [3:0]      valid_w, ready_w, tx_w, busy_w, done_w;
  logic [3:0][2:0] lvl_w;
  logic            ready_m, tx_m, busy_m, done_m;
  logic [2:0]      lvl_m;

  int n_checks = 0;
  int n_fail   = 0;
  int max_lvl3 = 0;

  typedef struct {
    logic [1:0] sel;
    logic [8:0] data;
    int         dbits;
    int         hasp;
    logic       par;
    int         stops;
    int         bn;
  } vec_t;
  vec_t vecs[3];

  always #5 clk = ~clk;

  assign valid_w = tb_valid ? (4'b0001 << sel) : 4'b0000;
  always_comb begin
    ready_m = ready_w[sel];
    tx_m    = tx_w[sel];
    busy_m  = busy_w[sel];
    done_m  = done_w[sel];
    lvl_m   = lvl_w[sel];
  end

  always @(negedge clk) if (int'(lvl_w[3]) > max_lvl3) max_lvl3 = int'(lvl_w[3]);

  uart_tx_fifo_param u0 (
    .clk(clk), .rstn(rstn), .tx_data_valid(valid_w[0]), .tx_data(tb_data[7:0]),
    .tx_data_ready(ready_w[0]), .tx(tx_w[0]), .tx_busy(busy_w[0]), .tx_done(done_w[0]),
    .fifo_level(lvl_w[0]));

  uart_tx_fifo_param #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u1 (
    .clk(clk), .rstn(rstn), .tx_data_valid(valid_w[1]), .tx_data(tb_data[6:0]),
    .tx_data_ready(ready_w[1]), .tx(tx_w[1]), .tx_busy(busy_w[1]), .tx_done(done_w[1]),
    .fifo_level(lvl_w[1]));

  uart_tx_fifo_param #(.PARITY(0)) u2 (
    .clk(clk), .rstn(rstn), .tx_data_valid(valid_w[2]), .tx_data(tb_data[7:0]),
    .tx_data_ready(ready_w[2]), .tx(tx_w[2]), .tx_busy(busy_w[2]), .tx_done(done_w[2]),
    .fifo_level(lvl_w[2]));

  uart_tx_fifo_param #(.BAUD_RATE(25_000_000)) u3 (
    .clk(clk), .rstn(rstn), .tx_data_valid(valid_w[3]), .tx_data(tb_data[7:0]),
    .tx_data_ready(ready_w[3]), .tx(tx_w[3]), .tx_busy(busy_w[3]), .tx_done(done_w[3]),
    .fifo_level(lvl_w[3]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [12:0] frame_bits(input logic [8:0] d, input int db, input int hp,
                                             input logic p, input int st);
    logic [12:0] b;
    int n;
    b = '1;
    b[0] = 1'b0;
    n = 1;
    for (int i = 0; i < db; i++) begin b[n] = d[i]; n++; end
    if (hp != 0) begin b[n] = p; n++; end
    for (int i = 0; i < st; i++) begin b[n] = 1'b1; n++; end
    return b;
  endfunction

  // Entered just after a negedge; the word is accepted on the following posedge.
  task automatic push(input logic [8:0] d);
    check("push ready", ready_m, 1);
    tb_data  = d;
    tb_valid = 1'b1;
    @(negedge clk);
    tb_valid = 1'b0;
  endtask

  // Samples every cycle of one frame on the selected DUT, starting with the next negedge.
  task automatic run_frame(input string name, input int bn, input int nbits, input logic [12:0] bits);
    int bad;
    int dones = 0;
    int done_at = -1;
    for (int k = 0; k < nbits; k++) begin
      bad = 0;
      for (int c = 0; c < bn; c++) begin
        @(negedge clk);
        if (tx_m !== bits[k]) bad++;
        if (done_m === 1'b1) begin dones++; done_at = k * bn + c; end
      end
      check($sformatf("%s bit%0d wrong-cycles", name, k), bad, 0);
    end
    check($sformatf("%s done count", name), dones, 1);
    check($sformatf("%s done cycle", name), done_at, nbits * bn - 1);
  endtask

  task automatic wait_idle(input string name, input int limit);
    int w = 0;
    while (busy_m && w < limit) begin @(negedge clk); w++; end
    check(name, busy_m, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0] w2[4];
    int w;
    int bad_tx, dones;
    vecs[0] = '{sel: 2'd0, data: 9'h0A5, dbits: 8, hasp: 1, par: 1'b1, stops: 1, bn: 434};
    vecs[1] = '{sel: 2'd1, data: 9'h041, dbits: 7, hasp: 1, par: 1'b0, stops: 2, bn: 434};
    vecs[2] = '{sel: 2'd3, data: 9'h001, dbits: 8, hasp: 1, par: 1'b0, stops: 1, bn: 2};
    w2[0] = 9'h000; w2[1] = 9'h0FF; w2[2] = 9'h055; w2[3] = 9'h03C;
    tb_valid = 1'b0;
    tb_data  = '0;
    sel      = 2'd0;
    rstn     = 1'b0;

    repeat (3) @(negedge clk);
    check("reset tx", tx_w, 4'hF);
    check("reset done", done_w, 4'h0);
    check("reset busy", busy_w, 4'h0);
    check("reset ready", ready_w, 4'hF);
    check("reset level", lvl_w, 12'h000);
    rstn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 3; i++) begin
      sel = vecs[i].sel;
      push(vecs[i].data);
      run_frame($sformatf("vec%0d", i), vecs[i].bn, 1 + vecs[i].dbits + vecs[i].hasp + vecs[i].stops,
                frame_bits(vecs[i].data, vecs[i].dbits, vecs[i].hasp, vecs[i].par, vecs[i].stops));
      @(negedge clk);
      check($sformatf("vec%0d idle busy", i), busy_m, 0);
      check($sformatf("vec%0d idle tx", i), tx_m, 1);
    end

    // Four words back-to-back, no parity: in order, gapless, one done per frame.
    sel = 2'd2;
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          check("b2b ready", ready_m, 1);
          tb_data  = w2[i];
          tb_valid = 1'b1;
          @(negedge clk);
        end
        tb_valid = 1'b0;
        check("b2b level", lvl_m, 3);
      end
      begin
        @(negedge clk);
        for (int i = 0; i < 4; i++)
          run_frame($sformatf("b2b%0d", i), 434, 10, frame_bits(w2[i], 8, 0, 1'b0, 1));
      end
    join
    check("b2b busy at last done", busy_m, 1);
    @(negedge clk);
    check("b2b busy after last done", busy_m, 0);

    // Fill the queue behind a running frame, then hold a fifth word across the pop.
    sel = 2'd3;
    push(9'h011);
    for (int i = 0; i < 4; i++) begin
      tb_data  = 9'h020 + 9'(i);
      tb_valid = 1'b1;
      @(negedge clk);
      check($sformatf("fill level %0d", i), lvl_m, i + 1);
      check($sformatf("fill ready %0d", i), ready_m, (i < 3) ? 1 : 0);
    end
    tb_data = 9'h0F5;
    w = 0;
    while (lvl_m == 3'd4 && w < 100) begin @(negedge clk); w++; end
    check("full pop level", lvl_m, 3);
    check("full pop ready", ready_m, 1);
    @(negedge clk);
    tb_valid = 1'b0;
    check("full late accept level", lvl_m, 4);
    check("full late accept ready", ready_m, 0);
    wait_idle("full drain idle", 500);
    check("full max level", max_lvl3, 4);

    // Reset in the middle of DATA with two words queued.
    sel = 2'd0;
    tb_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tb_data = 9'(i * 16);
      @(negedge clk);
    end
    tb_valid = 1'b0;
    check("rst queued level", lvl_m, 2);
    repeat (600) @(negedge clk);
    check("rst pre tx", tx_m, 0);
    check("rst pre busy", busy_m, 1);
    #3 rstn = 1'b0;
    #1;
    check("rst async tx", tx_m, 1);
    check("rst async level", lvl_m, 0);
    check("rst async ready", ready_m, 1);
    check("rst async busy", busy_m, 0);
    @(negedge clk);
    rstn = 1'b1;
    bad_tx = 0;
    dones = 0;
    repeat (2000) begin
      @(negedge clk);
      if (tx_m !== 1'b1) bad_tx++;
      if (done_m !== 1'b0) dones++;
    end
    check("post-rst tx idle cycles wrong", bad_tx, 0);
    check("post-rst spurious done", dones, 0);
    push(9'h0A5);
    run_frame("post-rst", 434, 11, frame_bits(9'h0A5, 8, 1, 1'b1, 1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
